ahb_arbiter: RTL
================

# ahb_arbiter

Two-master AHB-Lite arbiter that shares the single zero-wait-state system bus between master 0 (CPU data port) and master 1 (DMA engine).

- Grants one address phase per cycle.
- Tracks the outstanding data phase so HWDATA and HRDATA are steered to the master that owns it.
- Address and data phases of consecutive transfers overlap, so sustained throughput is one transfer per cycle.
- Sits between the masters and the bus decoder/mux/slave fabric.

## Interface
- MAXHOLD, 4: maximum consecutive beats the current owner keeps the bus while the other master is requesting (round-robin mode only); legal range 1..15.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  transfer request; held with addr/write until granted.
- m0_addr, m1_addr  in  32  transfer address.
- m0_write, m1_write  in  1  1 = write.
- m0_wdata, m1_wdata  in  32  write data, valid in the cycle after grant.
- m0_gnt, m1_gnt  out  1  address phase accepted this cycle (combinational).
- m0_done, m1_done  out  1  data phase of this master's transfer occurs this cycle.
- m0_rdata, m1_rdata  out  32  HRDATA when own done=1, else 0.
- HADDR  out  32  selected address; 0 when idle.
- HWRITE  out  1  selected write; 0 when idle.
- HTRANS  out  2  2'b10 NONSEQ when a grant is issued, 2'b00 IDLE otherwise.
- HWDATA  out  32  wdata of the data-phase owner; 0 when no data phase.
- HRDATA  in  32  read data from the bus mux, valid in the data phase.

## Operation
- Each cycle, at most one of m0_gnt/m1_gnt is 1, and only for a master whose req=1.
- The granted master's addr/write drive HADDR/HWRITE, and HTRANS=NONSEQ.
- Round-robin mode:
  - If only one master requests, it is granted.
  - If both request, the last owner keeps the bus while its streak count is below MAXHOLD; otherwise the other master is granted.
- Streak counter:
  - Incremented on a grant to the same owner.
  - Reloaded to 1 on an owner change.
  - Cleared on an idle cycle; an idle cycle also makes the next grant a fresh arbitration, with no priority memory except last_owner.
- Data-phase register (dvalid, downer) loads {gnt_any, granted id} every cycle.
- When dvalid=1:
  - HWDATA = wdata of downer.
  - m<downer>_done = 1.
  - m<downer>_rdata = HRDATA.
- A master that receives gnt may assert req again for its next transfer in the same cycle as its data phase (back-to-back).
- Simultaneous events: a new address phase and an outstanding data phase in the same cycle belong to independent masters or the same master, and both are honoured.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req and registered state. Data phase is exactly 1 cycle after the grant edge.
- Reset values:
  - last_owner = m1, so m0 wins the first contended arbitration.
  - streak = 0, dvalid = 0.
  - All gnt/done = 0; HADDR, HWRITE, HTRANS, HWDATA and all rdata = 0.
  - gnt is forced 0 while HRESETn=0.
- Reset mid-operation discards any pending data phase: done is never asserted for it, and no write is issued after reset release.
- Streak counter saturates and never wraps; its width is 4 bits.

## Configuration
- AHB_ARB_RR_EN defined: round-robin with MAXHOLD streak limit, as above.
- AHB_ARB_RR_EN undefined: fixed priority.
  - m0 always wins over m1.
  - MAXHOLD, streak counter and last_owner are not built.
  - m1 can starve.

## Structure
- Package ahb_arb_pkg holds:
  - The owner_t enum {OWN_M0, OWN_M1}.
  - HTRANS constants HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10.
- Sub-module ahb_arb_pick is the pure grant-selection logic: inputs are the reqs, last_owner and streak; the output is a one-hot gnt. It contains the `ifdef for the two policies.
- The top level contains the data-phase register, the output muxes and the streak/last_owner flops.

## Test plan
- Reset, then m0 reads 0x00020010 alone:
  - gnt0=1 with HADDR=0x00020010, HWRITE=0, HTRANS=2'b10.
  - Next cycle done0=1 and rdata0=HRDATA; all outputs 0 before the first req.
- m1 writes 0x20200004 with wdata 0x000000FF:
  - Grant cycle has HWRITE=1.
  - Next cycle HWDATA=0x000000FF and done1=1; HWDATA is 0 in the cycle after that.
- Both request continuously, RR, MAXHOLD=4: grants are m0 ×4, m1 ×4, m0 ×4, and so on; exactly one gnt per cycle.
- Back-to-back: m0 streams 3 reads and m1 is idle.
  - Three consecutive gnt0, then three consecutive done0, each rdata matching its address.
  - HTRANS is IDLE after the last grant.
- Assert HRESETn low one cycle after a grant to m1's write: done1 is never asserted, HWDATA=0 and HWRITE=0 during and after reset.
- AHB_ARB_RR_EN undefined, both requesting for 10 cycles: gnt0=1 in all 10 cycles and gnt1=0.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared owner encoding and HTRANS codes for the two-master AHB-Lite arbiter.
package ahb_arb_pkg;
  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
endpackage

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick: one-hot grant selection; AHB_ARB_RR_EN selects round-robin with MAXHOLD streak limit,
// otherwise fixed priority with m0 always winning.
`ifdef AHB_ARB_RR_EN
module ahb_arb_pick import ahb_arb_pkg::*; #(
  parameter int MAXHOLD = 4
) (
  input  logic       i_req0,
  input  logic       i_req1,
  input  owner_t     i_last_owner,
  input  logic [3:0] i_streak,
  output logic [1:0] o_gnt
);
  logic w_keep, w_pick1;
  // streak 0 means the bus went idle: fresh arbitration hands the turn to the other master
  assign w_keep  = (i_streak != 4'd0) && (i_streak < 4'(MAXHOLD));
  assign w_pick1 = i_req1 && (!i_req0 || ((i_last_owner == OWN_M1) ? w_keep : !w_keep));
  assign o_gnt   = {w_pick1, i_req0 && !w_pick1};
endmodule
`else
module ahb_arb_pick (
  input  logic       i_req0,
  input  logic       i_req1,
  output logic [1:0] o_gnt
);
  assign o_gnt = {i_req1 && !i_req0, i_req0};
endmodule
`endif

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB-Lite arbiter with data-phase steering; define AHB_ARB_RR_EN
// for round-robin (MAXHOLD streak limit), otherwise fixed priority to m0.
module ahb_arbiter import ahb_arb_pkg::*; `ifdef AHB_ARB_RR_EN #(
  parameter int MAXHOLD = 4
) `endif (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic        m0_write,
  input  logic        m1_write,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA
);
  logic [1:0] w_pick, w_gnt;
  logic       w_d0, w_d1;
  logic       r_dvalid;
  owner_t     r_downer;
`ifdef AHB_ARB_RR_EN
  owner_t     r_last_owner, w_gid;
  logic [3:0] r_streak;
  ahb_arb_pick #(.MAXHOLD(MAXHOLD)) u_pick (
    .i_req0(m0_req), .i_req1(m1_req), .i_last_owner(r_last_owner), .i_streak(r_streak), .o_gnt(w_pick)
  );
  assign w_gid = w_gnt[1] ? OWN_M1 : OWN_M0;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_last_owner <= OWN_M1;
      r_streak     <= 4'd0;
    end else if (!(|w_gnt)) begin
      r_streak <= 4'd0;
    end else begin
      r_last_owner <= w_gid;
      r_streak     <= (w_gid != r_last_owner) ? 4'd1 : (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
    end
`else
  ahb_arb_pick u_pick (.i_req0(m0_req), .i_req1(m1_req), .o_gnt(w_pick));
`endif
  assign w_gnt    = HRESETn ? w_pick : 2'b00;
  assign m0_gnt   = w_gnt[0];
  assign m1_gnt   = w_gnt[1];
  assign HADDR    = w_gnt[0] ? m0_addr : w_gnt[1] ? m1_addr : 32'd0;
  assign HWRITE   = w_gnt[0] ? m0_write : w_gnt[1] && m1_write;
  assign HTRANS   = (|w_gnt) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign w_d0     = r_dvalid && (r_downer == OWN_M0);
  assign w_d1     = r_dvalid && (r_downer == OWN_M1);
  assign m0_done  = w_d0;
  assign m1_done  = w_d1;
  assign m0_rdata = w_d0 ? HRDATA : 32'd0;
  assign m1_rdata = w_d1 ? HRDATA : 32'd0;
  assign HWDATA   = w_d0 ? m0_wdata : w_d1 ? m1_wdata : 32'd0;
  // an async reset drops any pending data phase so no stale done or write leaks out
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_dvalid <= 1'b0;
      r_downer <= OWN_M0;
    end else begin
      r_dvalid <= |w_gnt;
      r_downer <= w_gnt[1] ? OWN_M1 : OWN_M0;
    end
endmodule
